// File: rtl/freq_pkg.sv
// freq_pkg: shared FSM state type and default widths for the frequency meter
package freq_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE} state_t;
    localparam int CNT_W_DEF = 16;
    localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/freq_meter_if.sv
// freq_meter_if: measured input, enable and measurement results of freq_meter
interface freq_meter_if import freq_pkg::*; #(parameter int CNT_W = CNT_W_DEF);
    logic             sig_in;
    logic             enable;
    logic             edge_tick;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             overflow;
    modport master (output sig_in, enable, input edge_tick, period, period_valid, overflow);
    modport slave (input sig_in, enable, output edge_tick, period, period_valid, overflow);
endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det: synchronizes an asynchronous input and flags its rising edges
module sync_edge_det import freq_pkg::*; #(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    end
    assign rise = sync[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts clk cycles between rising edges of a slow asynchronous input
module freq_meter import freq_pkg::*; #(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic         clk,
    input  logic         reset,
    freq_meter_if.slave  bus
);
    localparam logic [CNT_W-1:0] MAX = '1;
    logic             rise;
    logic             full;
    logic             valid_n;
    logic             ovf_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] period_n;
    state_t           state;
    state_t           state_n;
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .reset(reset),
        .din  (bus.sig_in),
        .rise (rise)
    );
    assign full = cnt == MAX;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.period       <= '0;
            bus.period_valid <= 1'b0;
            bus.overflow     <= 1'b0;
            bus.edge_tick    <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            bus.period       <= period_n;
            bus.period_valid <= valid_n;
            bus.overflow     <= ovf_n;
            bus.edge_tick    <= rise;
        end
    end
    // a rise on a saturated count is an over-long period: no result, overflow kept
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        period_n = bus.period;
        valid_n  = 1'b0;
        ovf_n    = bus.overflow;
        case (state)
            IDLE: begin
                cnt_n   = '0;
                ovf_n   = 1'b0;
                state_n = bus.enable ? WAIT_EDGE : IDLE;
            end
            WAIT_EDGE: begin
                if (!bus.enable) state_n = IDLE;
                else if (rise) begin
                    cnt_n   = '0;
                    state_n = MEASURE;
                end
            end
            MEASURE: begin
                if (!bus.enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    ovf_n   = 1'b0;
                end else if (rise) begin
                    cnt_n    = '0;
                    ovf_n    = full;
                    valid_n  = ~full;
                    period_n = full ? bus.period : cnt + 1'b1;
                end else begin
                    cnt_n = full ? cnt : cnt + 1'b1;
                    ovf_n = bus.overflow | full;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed self-checking bench for freq_meter (CNT_W=8, SYNC_STAGES=2)
module tb_freq_meter;
    import freq_pkg::*;
    logic clk = 1'b0;
    logic reset;
    int total = 0, bad = 0;
    int cyc = 0, nval = 0, last_per = 0, lastv_cyc = 0, prevv_cyc = 0;
    int tick_cyc = 0, ovf_gap = -1, n0 = 0;
    logic ovf_q = 1'b0;

    freq_meter_if #(.CNT_W(8)) bus ();
    freq_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic s);
        bus.sig_in = s;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.edge_tick) tick_cyc = cyc;
        if (bus.period_valid) begin
            nval++;
            last_per  = int'(bus.period);
            prevv_cyc = lastv_cyc;
            lastv_cyc = cyc;
        end
        if (bus.overflow && !ovf_q) ovf_gap = cyc - tick_cyc;
        ovf_q = bus.overflow;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        repeat (n) begin
            repeat (hi) tick(1'b1);
            repeat (lo) tick(1'b0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tick"}, 32'(bus.edge_tick), 0);
        chk({tag, "_period"}, 32'(bus.period), 0);
        chk({tag, "_valid"}, 32'(bus.period_valid), 0);
        chk({tag, "_ovf"}, 32'(bus.overflow), 0);
    endtask

    initial begin
        reset = 1'b0;
        bus.enable = 1'b0;
        bus.sig_in = 1'b0;
        // reset held while sig_in toggles
        tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b1);
        chk_zero("rst_hold");
        reset = 1'b1;
        repeat (4) tick(1'b0);
        chk_zero("rst_rel");
        chk("rst_state", 32'(dut.state), 32'(IDLE));

        // latency and steady 32-cycle wave
        bus.enable = 1'b1;
        tick(1'b0);
        tick(1'b1);
        chk("lat_e1", 32'(bus.edge_tick), 0);
        tick(1'b1);
        chk("lat_e2", 32'(bus.edge_tick), 0);
        tick(1'b1);
        chk("lat_e3", 32'(bus.edge_tick), 1);
        chk("first_valid", 32'(bus.period_valid), 0);
        repeat (13) tick(1'b1);
        repeat (16) tick(1'b0);
        chk("first_nval", nval, 0);
        wave(16, 16, 3);
        chk("sq_nval", nval, 3);
        chk("sq_period", last_per, 32);
        chk("sq_spacing", lastv_cyc - prevv_cyc, 32);

        // range limits
        wave(5, 5, 3);
        chk("p10", last_per, 10);
        wave(128, 127, 2);
        chk("p255", last_per, 255);
        chk("p255_ovf", 32'(bus.overflow), 0);
        wave(2, 2, 4);
        chk("p4", last_per, 4);

        // overflow
        wave(150, 150, 1);
        chk("ovf_set", 32'(bus.overflow), 1);
        chk("ovf_gap", ovf_gap, 256);
        chk("ovf_hold_per", 32'(bus.period), 4);
        n0 = nval;
        wave(150, 150, 1);
        chk("ovf_no_valid", nval, n0);
        chk("ovf_still", 32'(bus.overflow), 1);
        wave(50, 50, 1);
        chk("sw1_ovf", 32'(bus.overflow), 1);
        chk("sw1_per", 32'(bus.period), 4);
        wave(50, 50, 1);
        chk("sw2_per", last_per, 100);
        chk("sw2_ovf", 32'(bus.overflow), 0);

        // enable drop coinciding with a rise
        wave(150, 150, 1);
        chk("en_pre_ovf", 32'(bus.overflow), 1);
        n0 = nval;
        tick(1'b1);
        tick(1'b1);
        bus.enable = 1'b0;
        tick(1'b1);
        chk("en_tick", 32'(bus.edge_tick), 1);
        chk("en_valid", 32'(bus.period_valid), 0);
        tick(1'b1);
        chk("en_ovf_clr", 32'(bus.overflow), 0);
        chk("en_per_hold", 32'(bus.period), 100);
        chk("en_nval", nval, n0);
        chk("en_state", 32'(dut.state), 32'(IDLE));
        repeat (12) tick(1'b1);
        repeat (16) tick(1'b0);
        bus.enable = 1'b1;
        tick(1'b0);
        n0 = nval;
        wave(16, 16, 1);
        chk("reen_first", nval, n0);
        chk("reen_per_hold", 32'(bus.period), 100);
        wave(16, 16, 1);
        chk("reen_second", nval, n0 + 1);
        chk("reen_per", last_per, 32);

        // asynchronous reset mid-measurement
        wave(16, 16, 1);
        repeat (5) tick(1'b1);
        chk("pre_arst_per", 32'(bus.period), 32);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_zero("arst");
        chk("arst_state", 32'(dut.state), 32'(IDLE));
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.sig_in = 1'b0;
        ovf_q = 1'b0;
        repeat (16) tick(1'b0);
        n0 = nval;
        wave(16, 16, 2);
        chk("post_arst_nval", nval, n0 + 1);
        chk("post_arst_per", last_per, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/freq_meter.md
# freq_meter

Measures the period of a slow external square wave in cycles of the system clock. A typical input is the divided clock produced by the design's frequency divider, or any other asynchronous slow signal. The block synchronizes the input, detects rising edges, and counts `clk` cycles between consecutive edges. Each measurement is published with a one-cycle valid pulse, and an overflow flag reports periods too long to count. It is the measuring counterpart of the divider chain and is used to self-check divider outputs on the board.

## Interface
- `CNT_W`, default 16: period counter and `period` output width.
- `SYNC_STAGES`, default 2: synchronizer flops on `sig_in`, minimum 2.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset. 0 resets all state; 1 is normal operation.
- `sig_in`  in  1  asynchronous signal to be measured.
- `enable`  in  1  measurement enable, synchronous to `clk`.
- `edge_tick`  out  1  one-cycle pulse per detected rising edge of synchronized `sig_in`. Independent of `enable`.
- `period`  out  CNT_W  last valid period in `clk` cycles. Held between measurements.
- `period_valid`  out  1  one-cycle pulse when `period` is updated.
- `overflow`  out  1  set when the count saturates; cleared as described under Operation.

## Operation
- Synchronizer: `SYNC_STAGES` flops, then a previous-sample flop. `rise` = sync_out & ~prev (combinational, internal).
- FSM states: IDLE, WAIT_EDGE, MEASURE. Reset state is IDLE.
  - IDLE: `cnt` = 0 and `overflow` = 0. If `enable`=1, go to WAIT_EDGE; a `rise` in the same cycle is ignored.
  - WAIT_EDGE: on `rise`, clear `cnt` to 0 and go to MEASURE. No `period_valid` is produced. If `enable`=0, go to IDLE.
  - MEASURE, no `rise`: `cnt` increments and saturates at all-ones. When `cnt` reaches all-ones, set `overflow`=1.
  - MEASURE, `rise` with `cnt` < all-ones:
    - `period` <= `cnt`+1 and `period_valid`=1.
    - `overflow` <= 0 and `cnt` <= 0.
    - Stay in MEASURE.
  - MEASURE, `rise` with `cnt` = all-ones: no `period_valid` and `period` unchanged. `overflow` stays 1, `cnt` <= 0, stay in MEASURE.
  - MEASURE, `enable`=0: go to IDLE. `enable`=0 has priority over a simultaneous `rise`; no valid pulse is produced. `period` is held.
- Measurable range: 2 to 2^CNT_W − 1 cycles. A period of 2^CNT_W or more reports `overflow`.
- Input requirement: `sig_in` must stay high for at least 2 `clk` cycles and low for at least 2. Shorter pulses may be missed and are not checked.
- Reset values: `edge_tick`=0, `period`=0, `period_valid`=0, `overflow`=0. The sync chain and prev flop reset to 0.
- If `sig_in` is already high at reset release, one `rise` is detected after synchronization and is treated as a real edge.

## Timing
- Counting the `clk` edge that first samples `sig_in` high as edge 1: `rise` is true after edge `SYNC_STAGES`.
- `edge_tick`, `period_valid` and the new `period` are registered and become visible together after edge `SYNC_STAGES`+1.
- Ticks spaced N cycles apart report `period`=N.
- After `enable` rises, the first valid result appears on the second detected edge.
- `overflow` rises one cycle after `cnt` reaches all-ones.
- Asserting `reset` low clears all outputs immediately, without a clock edge. After release, the block is in IDLE.

## Structure
- Shared package `freq_pkg` holds:
  - the FSM state enum (IDLE, WAIT_EDGE, MEASURE);
  - the default constants for `CNT_W` and `SYNC_STAGES`.
- Sub-module `sync_edge_det` (parameter `SYNC_STAGES`) contains the synchronizer, prev flop and `rise` output. It is reusable for buttons and other asynchronous inputs.
- The top level holds the FSM, counter and output registers.

## Test plan
All scenarios use CNT_W=8 and SYNC_STAGES=2.
- Reset: hold `reset`=0 while driving `sig_in` → all outputs 0. Release with `sig_in`=0 and `enable`=0 → outputs remain 0 and state is IDLE.
- Steady square wave: `enable`=1, `sig_in` period 32 (16 high / 16 low).
  - The first `edge_tick` produces no valid pulse.
  - Every later edge gives `period_valid` with `period`=32, pulses 32 cycles apart.
  - Latency: `edge_tick` appears 3 edges after `sig_in` is first sampled high.
- Range limits, `sig_in` period switched at a rising edge:
  - Period 10 → `period`=10.
  - Period 255 → `period`=255 with `overflow`=0.
  - Period 4 (2 high / 2 low) → `period`=4.
- Overflow:
  - Period 300 → `overflow`=1 about 255 cycles after a tick, with no `period_valid` and `period` held.
  - Switch to period 100 → the second edge after the switch gives `period`=100 and `overflow`=0.
- Enable control:
  - Deassert `enable` mid-MEASURE, with a `rise` in the same cycle → no `period_valid`, `overflow` cleared, `edge_tick` still pulses.
  - Reassert `enable` → the first valid result comes two edges later.
- Asynchronous reset: drop `reset` between `clk` edges mid-MEASURE → outputs are 0 before the next `clk` edge. After release, sampling resumes from IDLE.
